// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU port: port and command codes, status bit
// positions, sequencer states and the status byte packer.
package vdp_cpu_port_pkg;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  localparam logic [1:0] CMD_RDADDR = 2'b00;
  localparam logic [1:0] CMD_WRADDR = 2'b01;
  localparam logic [1:0] CMD_REG    = 2'b10;
  localparam logic [1:0] CMD_HIADDR = 2'b11;

  localparam int STAT_BUSY    = 7;
  localparam int STAT_VALID   = 6;
  localparam int STAT_OVERRUN = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WRITE_REQ = 2'b01,
    ST_READ_REQ  = 2'b10,
    ST_READ_WAIT = 2'b11
  } state_t;

  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic valid,
                                             input logic overrun);
    logic [7:0] s;
    s               = 8'h00;
    s[STAT_BUSY]    = busy;
    s[STAT_VALID]   = valid;
    s[STAT_OVERRUN] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/vdp_cpu_port.sv
// CPU-facing front end of the VDP: decodes data/control port accesses into
// register writes and arbitrated VRAM reads/writes with an auto-incrementing address.
module vdp_cpu_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int RamBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuWrite,
  input  logic               cpuRead,
  input  logic               cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               cpuBusy,
  output logic               regWrite,
  output logic [2:0]         regIndex,
  output logic [7:0]         regData,
  output logic               vramReq,
  input  logic               vramGrant,
  output logic               vramWe,
  output logic [RamBits-1:0] vramAddress,
  output logic [7:0]         vramDataOut,
  input  logic [7:0]         vramDataIn
);

  state_t             state_r, state_s;
  logic               phase_r;
  logic [7:0]         byte1_r;
  logic [RamBits-1:0] addr_r;
  logic [7:0]         latch_r;
  logic               latch_valid_r;
  logic               overrun_r;

  logic               busy_s, ctrl_wr_s, data_wr_s, data_rd_s, ctrl_rd_s;
  logic               rdaddr_s, start_wr_s, start_rd_s, reject_s;
  logic [1:0]         cmd_s;
  logic [13:0]        addr_lo_s;
  logic [RamBits-1:0] addr_inc_s;

  // Access decode; busy is taken from the current state so a grant in the same cycle does not admit a new access
  always_comb begin
    busy_s     = (state_r != ST_IDLE);
    ctrl_wr_s  = cpuWrite && (cpuPort == PORT_CTRL);
    data_wr_s  = cpuWrite && (cpuPort == PORT_DATA);
    data_rd_s  = !cpuWrite && cpuRead && (cpuPort == PORT_DATA);
    ctrl_rd_s  = !cpuWrite && cpuRead && (cpuPort == PORT_CTRL);
    cmd_s      = cpuDataIn[7:6];
    rdaddr_s   = ctrl_wr_s && phase_r && (cmd_s == CMD_RDADDR);
    start_wr_s = data_wr_s && !busy_s;
    start_rd_s = (data_rd_s || rdaddr_s) && !busy_s;
    reject_s   = (data_wr_s || data_rd_s || rdaddr_s) && busy_s;
    addr_lo_s  = {cpuDataIn[5:0], byte1_r};
    addr_inc_s = addr_r + RamBits'(1);
  end

  // VRAM sequencer next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_wr_s)      state_s = ST_WRITE_REQ;
        else if (start_rd_s) state_s = ST_READ_REQ;
        else                 state_s = ST_IDLE;
      end
      ST_WRITE_REQ: begin
        if (vramGrant) state_s = ST_IDLE;
        else           state_s = ST_WRITE_REQ;
      end
      ST_READ_REQ: begin
        if (vramGrant) state_s = ST_READ_WAIT;
        else           state_s = ST_READ_REQ;
      end
      ST_READ_WAIT: state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Sequencer state register; reset drops any pending request at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  assign cpuBusy = busy_s;
  assign vramReq = (state_r == ST_WRITE_REQ) || (state_r == ST_READ_REQ);
  assign vramWe  = (state_r == ST_WRITE_REQ);

  // Byte pairing, address counter, read-ahead latch and the captured VRAM operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r       <= 1'b0;
      byte1_r       <= 8'h00;
      addr_r        <= '0;
      latch_r       <= 8'h00;
      latch_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      cpuDataOut    <= 8'h00;
      regWrite      <= 1'b0;
      regIndex      <= 3'd0;
      regData       <= 8'h00;
      vramAddress   <= '0;
      vramDataOut   <= 8'h00;
    end else begin
      regWrite <= 1'b0;
      if (state_r == ST_READ_WAIT) begin
        latch_r       <= vramDataIn;
        latch_valid_r <= 1'b1;
      end
      if (ctrl_wr_s) begin
        if (!phase_r) begin
          byte1_r <= cpuDataIn;
          phase_r <= 1'b1;
        end else begin
          phase_r <= 1'b0;
          case (cmd_s)
            CMD_RDADDR: begin
              if (!busy_s) begin
                addr_r[13:0]  <= addr_lo_s;
                vramAddress   <= {addr_r[RamBits-1:14], addr_lo_s};
                latch_valid_r <= 1'b0;
              end
            end
            CMD_WRADDR: addr_r[13:0] <= addr_lo_s;
            CMD_REG: begin
              regWrite <= 1'b1;
              regIndex <= cpuDataIn[2:0];
              regData  <= byte1_r;
            end
            CMD_HIADDR: addr_r[RamBits-1:14] <= byte1_r[RamBits-15:0];
            default:    phase_r <= 1'b0;
          endcase
        end
      end else if (data_wr_s) begin
        if (!busy_s) begin
          vramAddress <= addr_r;
          vramDataOut <= cpuDataIn;
          addr_r      <= addr_inc_s;
        end
      end else if (data_rd_s) begin
        if (!busy_s) begin
          cpuDataOut  <= latch_r;
          addr_r      <= addr_inc_s;
          vramAddress <= addr_inc_s;
        end
      end else if (ctrl_rd_s) begin
        cpuDataOut <= status_byte(busy_s, latch_valid_r, overrun_r);
        overrun_r  <= 1'b0;
        phase_r    <= 1'b0;
      end
      if (reject_s) overrun_r <= 1'b1;
    end
  end

endmodule
